// File: rtl/fadd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fadd_pkg
// Description : Shared constants and types for the FP adder family.
//               Holds per-format widths (fp16/fp32/fp64) and the result
//               bundle produced by the close-path leading-zero anticipator.
//               The bundle is sized for the widest format; narrower builds
//               zero-extend into it.
// Revision    : 1.0  initial release
// ============================================================================
package fadd_pkg;

  // fp16
  localparam int c_fp16_frac_w    = 10;
  localparam int c_fp16_exp_w     = 5;
  localparam int c_fp16_frac_in_w = 2*c_fp16_frac_w + 1;
  localparam int c_fp16_lzc_w     = 32;
  localparam int c_fp16_sum_w     = c_fp16_frac_w + 4;

  // fp32
  localparam int c_fp32_frac_w    = 23;
  localparam int c_fp32_exp_w     = 8;
  localparam int c_fp32_frac_in_w = 2*c_fp32_frac_w + 1;
  localparam int c_fp32_lzc_w     = 128;
  localparam int c_fp32_sum_w     = c_fp32_frac_w + 4;

  // fp64
  localparam int c_fp64_frac_w    = 52;
  localparam int c_fp64_exp_w     = 11;
  localparam int c_fp64_frac_in_w = 2*c_fp64_frac_w + 1;
  localparam int c_fp64_lzc_w     = 256;
  localparam int c_fp64_sum_w     = c_fp64_frac_w + 4;

  // Widest format bounds the result bundle.
  localparam int c_lza_max_sum_w   = c_fp64_sum_w;
  localparam int c_lza_max_shift_w = $clog2(c_fp64_lzc_w);

  typedef struct packed {
    logic                         limited;
    logic [c_lza_max_shift_w-1:0] lza;
    logic [c_lza_max_sum_w-1:0]   overflow_l_mask;
    logic [c_lza_max_sum_w-1:0]   overflow_g_mask;
    logic [c_lza_max_sum_w-1:0]   normal_l_mask;
    logic [c_lza_max_sum_w-1:0]   normal_g_mask;
    logic [c_lza_max_sum_w-1:0]   overflow_s_mask;
    logic [c_lza_max_sum_w-1:0]   normal_s_mask;
  } lza_res_t;

endpackage
`default_nettype wire

// File: rtl/fadd_lza_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : fadd_lza_pipe_if
// Description : Handshake and data bundle of the close-path LZA pipeline.
//               slave  : the LZA pipeline itself
//               master : upstream driver / downstream consumer
// Signals     : flush_i, in_valid_i/in_ready_o, frac_large_i, frac_small_i,
//               exp_large_i, small_rsh1_i, out_valid_o/out_ready_i,
//               lza_limited_by_exp_o, lza_o and the six normalisation masks.
// Revision    : 1.0  initial release
// ============================================================================
interface fadd_lza_pipe_if #(
  parameter int FRAC_W    = 10,
  parameter int EXP_W     = 5,
  parameter int FRAC_IN_W = 2*FRAC_W + 1,
  parameter int LZC_W     = 32,
  parameter int SUM_W     = FRAC_W + 4,
  parameter int SHIFT_W   = $clog2(LZC_W)
);
  logic                 flush_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [FRAC_IN_W-1:0] frac_large_i;
  logic [FRAC_IN_W-1:0] frac_small_i;
  logic [EXP_W-1:0]     exp_large_i;
  logic                 small_rsh1_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 lza_limited_by_exp_o;
  logic [SHIFT_W-1:0]   lza_o;
  logic [SUM_W-1:0]     overflow_l_mask_o;
  logic [SUM_W-2:0]     overflow_g_mask_o;
  logic [SUM_W-2:0]     normal_l_mask_o;
  logic [SUM_W-3:0]     normal_g_mask_o;
  logic [SUM_W-3:0]     overflow_s_mask_o;
  logic [SUM_W-4:0]     normal_s_mask_o;

  modport slave (
    input  flush_i, in_valid_i, frac_large_i, frac_small_i, exp_large_i,
           small_rsh1_i, out_ready_i,
    output in_ready_o, out_valid_o, lza_limited_by_exp_o, lza_o,
           overflow_l_mask_o, overflow_g_mask_o, normal_l_mask_o,
           normal_g_mask_o, overflow_s_mask_o, normal_s_mask_o
  );

  modport master (
    output flush_i, in_valid_i, frac_large_i, frac_small_i, exp_large_i,
           small_rsh1_i, out_ready_i,
    input  in_ready_o, out_valid_o, lza_limited_by_exp_o, lza_o,
           overflow_l_mask_o, overflow_g_mask_o, normal_l_mask_o,
           normal_g_mask_o, overflow_s_mask_o, normal_s_mask_o
  );
endinterface
`default_nettype wire

// File: rtl/fadd_lza_mask_gen.sv
`default_nettype none
// ============================================================================
// Module      : fadd_lza_mask_gen
// Description : Converts a left-shift amount into the one-hot L/G masks and
//               thermometer S masks used by the normalising shifter for the
//               Overflow and Normal result cases.
// Ports       : i_lza             - left-shift amount
//               o_overflow_l_mask - one-hot at SUM_W-1-lza (0 if out of range)
//               o_overflow_g_mask - overflow_l >> 1
//               o_normal_l_mask   - equal to overflow_g
//               o_normal_g_mask   - normal_l >> 1
//               o_overflow_s_mask - bit j set when j <= SUM_W-3-lza
//               o_normal_s_mask   - overflow_s >> 1
// Revision    : 1.0  initial release
// ============================================================================
module fadd_lza_mask_gen #(
  parameter int SUM_W   = 14,
  parameter int SHIFT_W = 5
) (
  input  wire logic [SHIFT_W-1:0] i_lza,
  output logic      [SUM_W-1:0]   o_overflow_l_mask,
  output logic      [SUM_W-2:0]   o_overflow_g_mask,
  output logic      [SUM_W-2:0]   o_normal_l_mask,
  output logic      [SUM_W-3:0]   o_normal_g_mask,
  output logic      [SUM_W-3:0]   o_overflow_s_mask,
  output logic      [SUM_W-4:0]   o_normal_s_mask
);

  // Comparisons in int arithmetic so lza >= SUM_W naturally yields empty masks.
  always_comb begin
    o_overflow_l_mask = '0;
    o_overflow_s_mask = '0;
    for (int j = 0; j < SUM_W; j++) begin
      o_overflow_l_mask[j] = (int'(i_lza) + j == SUM_W - 1);
    end
    for (int j = 0; j < SUM_W - 2; j++) begin
      o_overflow_s_mask[j] = (int'(i_lza) + j <= SUM_W - 3);
    end
  end

  assign o_overflow_g_mask = o_overflow_l_mask[SUM_W-1:1];
  assign o_normal_l_mask   = o_overflow_g_mask;
  assign o_normal_g_mask   = o_normal_l_mask[SUM_W-2:1];
  assign o_normal_s_mask   = o_overflow_s_mask[SUM_W-3:1];

endmodule
`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// ============================================================================
// Module      : lzc
// Description : Combinational zero counter.
//               MODE=1 counts leading zeros (from the MSB),
//               MODE=0 counts trailing zeros (from the LSB).
// Ports       : i_data  - vector to scan
//               o_cnt   - zero count (0 when i_data is all-zero)
//               o_empty - i_data is all-zero
// Revision    : 1.0  initial release
// ============================================================================
module lzc #(
  parameter int WIDTH = 32,
  parameter int MODE  = 1,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [CNT_W-1:0] o_cnt,
  output logic                  o_empty
);

  generate
    if (MODE == 1) begin : g_leading
      // Scan upward so the highest set bit is the last to write.
      always_comb begin
        o_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (i_data[i]) o_cnt = CNT_W'(WIDTH - 1 - i);
        end
      end
    end else begin : g_trailing
      always_comb begin
        o_cnt = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (i_data[i]) o_cnt = CNT_W'(i);
        end
      end
    end
  endgenerate

  assign o_empty = ~|i_data;

endmodule
`default_nettype wire

// File: rtl/fadd_lza_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fadd_lza_pipe
// Description : Pipelined leading-zero anticipator for the FP adder close
//               path. Builds the LZA detection vector from the aligned
//               fractions, merges in the exponent clamp, counts leading
//               zeros and expands the count into normalisation masks.
//               Stage 1 registers (v | lim) and the limited flag, stage 2
//               registers the count and masks. valid/ready on both sides.
// Ports       : clk, rst (synchronous, active-high)
//               bus (fadd_lza_pipe_if.slave) - handshake, operands, results
// Build macro : FADD_LZA_SINGLE_STAGE_EN - removes the stage-1 register,
//               latency becomes 1, result values unchanged.
// Revision    : 1.0  initial release
// ============================================================================
module fadd_lza_pipe
  import fadd_pkg::*;
#(
  parameter int FRAC_W    = c_fp16_frac_w,
  parameter int EXP_W     = c_fp16_exp_w,
  parameter int FRAC_IN_W = 2*FRAC_W + 1,
  parameter int LZC_W     = c_fp16_lzc_w,
  parameter int SUM_W     = FRAC_W + 4,
  parameter int SHIFT_W   = $clog2(LZC_W)
) (
  input  wire logic      clk,
  input  wire logic      rst,
  fadd_lza_pipe_if.slave bus
);

  localparam int c_og_w = SUM_W - 1;
  localparam int c_ng_w = SUM_W - 2;
  localparam int c_ns_w = SUM_W - 3;

  // ---------------------------------------------------------------- detection
  logic [LZC_W-1:0] w_a;
  logic [LZC_W-1:0] w_b;
  logic [LZC_W-1:0] w_v;
  logic [LZC_W-1:0] w_lim;
  logic [LZC_W-1:0] w_above;
  logic [LZC_W-1:0] w_vec;
  logic             w_limited;
  int               w_exp;
  int               w_hi;

  // Hidden bit is always 1; the small operand optionally arrives pre-shifted.
  assign w_a = {1'b1, bus.frac_large_i, {(LZC_W-1-FRAC_IN_W){1'b0}}};
  assign w_b = bus.small_rsh1_i
             ? ~{2'b01, bus.frac_small_i, {(LZC_W-2-FRAC_IN_W){1'b0}}}
             : ~{1'b1,  bus.frac_small_i, {(LZC_W-1-FRAC_IN_W){1'b0}}};

  always_comb begin
    w_v = '0;
    for (int i = 0; i < LZC_W - 1; i++) begin
      w_v[i] = ~((w_a[i+1] ^ w_b[i+1]) ^ (~w_a[i] & ~w_b[i]));
    end
  end

  // Exponent clamp: the shift may not take the exponent below 1. Bit 0 is
  // always set so the count never runs past the vector.
  always_comb begin
    w_exp = int'(bus.exp_large_i);
    if (w_exp <= 1)              w_hi = LZC_W - 1;
    else if (w_exp <= LZC_W - 1) w_hi = LZC_W - w_exp;
    else                         w_hi = 0;
    w_lim   = '0;
    w_above = '0;
    for (int i = 0; i < LZC_W; i++) begin
      w_lim[i]   = (i == 0) || (i == w_hi);
      w_above[i] = (i > w_hi);
    end
  end

  assign w_vec     = w_v | w_lim;
  assign w_limited = ~|(w_v & w_above);

  // ---------------------------------------------------------------- stage 1
  logic             w_s2_advance;
  logic             w_in_ready;
  logic             w_s1_valid;
  logic [LZC_W-1:0] w_s1_vec;
  logic             w_s1_limited;
  logic             r_s2_valid;

  assign w_s2_advance = ~r_s2_valid | bus.out_ready_i;

`ifdef FADD_LZA_SINGLE_STAGE_EN
  assign w_in_ready   = w_s2_advance;
  assign w_s1_valid   = bus.in_valid_i;
  assign w_s1_vec     = w_vec;
  assign w_s1_limited = w_limited;
`else
  logic             r_s1_valid;
  logic [LZC_W-1:0] r_s1_vec;
  logic             r_s1_limited;

  assign w_in_ready = ~r_s1_valid | w_s2_advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_vec     <= '0;
      r_s1_limited <= 1'b0;
    end else if (bus.flush_i) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        r_s1_vec     <= w_vec;
        r_s1_limited <= w_limited;
      end
    end
  end

  assign w_s1_valid   = r_s1_valid;
  assign w_s1_vec     = r_s1_vec;
  assign w_s1_limited = r_s1_limited;
`endif

  assign bus.in_ready_o = w_in_ready;

  // ---------------------------------------------------------------- stage 2
  logic [SHIFT_W-1:0] w_lza;
  logic               w_unused_empty;
  logic [SUM_W-1:0]   w_ovl;
  logic [SUM_W-2:0]   w_ovg;
  logic [SUM_W-2:0]   w_nl;
  logic [SUM_W-3:0]   w_ng;
  logic [SUM_W-3:0]   w_ovs;
  logic [SUM_W-4:0]   w_ns;
  lza_res_t           r_s2_res;

  lzc #(
    .WIDTH (LZC_W),
    .MODE  (1)
  ) u_lzc (
    .i_data  (w_s1_vec),
    .o_cnt   (w_lza),
    .o_empty (w_unused_empty)
  );

  fadd_lza_mask_gen #(
    .SUM_W   (SUM_W),
    .SHIFT_W (SHIFT_W)
  ) u_mask_gen (
    .i_lza             (w_lza),
    .o_overflow_l_mask (w_ovl),
    .o_overflow_g_mask (w_ovg),
    .o_normal_l_mask   (w_nl),
    .o_normal_g_mask   (w_ng),
    .o_overflow_s_mask (w_ovs),
    .o_normal_s_mask   (w_ns)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
    end else if (bus.flush_i) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_advance) begin
      r_s2_valid <= w_s1_valid;
      if (w_s1_valid) begin
        r_s2_res.limited         <= w_s1_limited;
        r_s2_res.lza             <= c_lza_max_shift_w'(w_lza);
        r_s2_res.overflow_l_mask <= c_lza_max_sum_w'(w_ovl);
        r_s2_res.overflow_g_mask <= c_lza_max_sum_w'(w_ovg);
        r_s2_res.normal_l_mask   <= c_lza_max_sum_w'(w_nl);
        r_s2_res.normal_g_mask   <= c_lza_max_sum_w'(w_ng);
        r_s2_res.overflow_s_mask <= c_lza_max_sum_w'(w_ovs);
        r_s2_res.normal_s_mask   <= c_lza_max_sum_w'(w_ns);
      end
    end
  end

  assign bus.out_valid_o          = r_s2_valid;
  assign bus.lza_limited_by_exp_o = r_s2_res.limited;
  assign bus.lza_o                = SHIFT_W'(r_s2_res.lza);
  assign bus.overflow_l_mask_o    = SUM_W'(r_s2_res.overflow_l_mask);
  assign bus.overflow_g_mask_o    = c_og_w'(r_s2_res.overflow_g_mask);
  assign bus.normal_l_mask_o      = c_og_w'(r_s2_res.normal_l_mask);
  assign bus.normal_g_mask_o      = c_ng_w'(r_s2_res.normal_g_mask);
  assign bus.overflow_s_mask_o    = c_ng_w'(r_s2_res.overflow_s_mask);
  assign bus.normal_s_mask_o      = c_ns_w'(r_s2_res.normal_s_mask);

endmodule
`default_nettype wire

// File: tb/tb_fadd_lza_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fadd_lza_pipe
// Description : Self-checking bench for fadd_lza_pipe (fp16 configuration).
//               Directed vector table, backpressure stream, flush, mid-run
//               reset and an exponent sweep against a reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fadd_lza_pipe;

  localparam int FRAC_W    = 10;
  localparam int EXP_W     = 5;
  localparam int FRAC_IN_W = 21;
  localparam int LZC_W     = 32;
  localparam int SUM_W     = 14;
  localparam int SHIFT_W   = 5;
`ifdef FADD_LZA_SINGLE_STAGE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic        lim;
    logic [4:0]  lza;
    logic [13:0] ovl;
    logic [12:0] ovg;
    logic [12:0] nl;
    logic [11:0] ng;
    logic [11:0] ovs;
    logic [10:0] ns;
  } res_t;

  typedef struct packed {
    logic [20:0] fl;
    logic [20:0] fs;
    logic [4:0]  e;
    logic        r;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fadd_lza_pipe_if #(
    .FRAC_W(FRAC_W), .EXP_W(EXP_W), .FRAC_IN_W(FRAC_IN_W),
    .LZC_W(LZC_W), .SUM_W(SUM_W), .SHIFT_W(SHIFT_W)
  ) bus ();

  fadd_lza_pipe #(
    .FRAC_W(FRAC_W), .EXP_W(EXP_W), .FRAC_IN_W(FRAC_IN_W),
    .LZC_W(LZC_W), .SUM_W(SUM_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t read_dut();
    res_t m;
    m.lim = bus.lza_limited_by_exp_o;
    m.lza = bus.lza_o;
    m.ovl = bus.overflow_l_mask_o;
    m.ovg = bus.overflow_g_mask_o;
    m.nl  = bus.normal_l_mask_o;
    m.ng  = bus.normal_g_mask_o;
    m.ovs = bus.overflow_s_mask_o;
    m.ns  = bus.normal_s_mask_o;
    return m;
  endfunction

  function automatic res_t mk(logic lim, int lza, int ovl, int ovg, int nl,
                              int ng, int ovs, int ns);
    res_t m;
    m.lim = lim;       m.lza = 5'(lza);
    m.ovl = 14'(ovl);  m.ovg = 13'(ovg);
    m.nl  = 13'(nl);   m.ng  = 12'(ng);
    m.ovs = 12'(ovs);  m.ns  = 11'(ns);
    return m;
  endfunction

  // Reference model written from the detection/clamp/mask definitions.
  function automatic res_t model(logic [20:0] fl, logic [20:0] fs,
                                 logic [4:0] e, logic r);
    logic [31:0] a, b, v, x, t;
    int hl, msb, lza;
    res_t m;
    a = {1'b1, fl, 10'd0};
    b = r ? ~{2'b01, fs, 9'd0} : ~{1'b1, fs, 10'd0};
    v = '0;
    for (int i = 0; i < 31; i++) v[i] = ~((a[i+1] ^ b[i+1]) ^ (~a[i] & ~b[i]));
    hl = (e <= 5'd1) ? 31 : 32 - int'(e);
    x = v;
    x[hl] = 1'b1;
    x[0]  = 1'b1;
    msb = 0;
    for (int i = 31; i >= 0; i--) begin
      if (x[i]) begin msb = i; break; end
    end
    lza = 31 - msb;
    m = '0;
    m.lim = (msb == hl);
    m.lza = 5'(lza);
    if (lza <= 13) begin t = 32'd1 << (13 - lza); m.ovl = t[13:0]; end
    m.ovg = m.ovl[13:1];
    m.nl  = m.ovg;
    m.ng  = m.nl[12:1];
    if (lza <= 11) begin t = (32'd1 << (12 - lza)) - 32'd1; m.ovs = t[11:0]; end
    m.ns  = m.ovs[11:1];
    return m;
  endfunction

  task automatic check_res(string name, res_t got, res_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic check_int(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  task automatic drive(logic [20:0] fl, logic [20:0] fs, logic [4:0] e, logic r);
    bus.frac_large_i = fl;
    bus.frac_small_i = fs;
    bus.exp_large_i  = e;
    bus.small_rsh1_i = r;
  endtask

  // Send one operand set with out_ready high and check its result.
  task automatic run_one(string name, logic [20:0] fl, logic [20:0] fs,
                         logic [4:0] e, logic r, res_t exp, logic chk_lat);
    int guard, lat;
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    drive(fl, fs, e, r);
    #1;
    guard = 0;
    while (!bus.in_ready_o && guard < 20) begin tick(); guard++; end
    tick();
    bus.in_valid_i = 1'b0;
    lat = 1;
    while (!bus.out_valid_o && lat < 10) begin tick(); lat++; end
    if (!bus.out_valid_o) check_int({name, "_timeout"}, 0, 1);
    else begin
      check_res(name, read_dut(), exp);
      if (chk_lat) check_int({name, "_latency"}, lat, LAT);
    end
  endtask

  vec_t tbl[13];
  res_t stream_exp[8];

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    drive('0, '0, '0, 1'b0);

    tbl[0]  = '{fl:21'h0,     fs:21'h0,     e:5'd5,  r:1'b0, exp:mk(1, 4, 'h200, 'h100, 'h100, 'h080, 'h0FF, 'h07F)};
    tbl[1]  = '{fl:21'h0,     fs:21'h0,     e:5'd20, r:1'b1, exp:mk(0, 2, 'h800, 'h400, 'h400, 'h200, 'h3FF, 'h1FF)};
    tbl[2]  = '{fl:21'h1ABCD, fs:21'h0F0F0, e:5'd1,  r:1'b0, exp:mk(1, 0, 'h2000, 'h1000, 'h1000, 'h800, 'hFFF, 'h7FF)};
    tbl[3]  = '{fl:21'h15555, fs:21'h1FFFF, e:5'd0,  r:1'b1, exp:mk(1, 0, 'h2000, 'h1000, 'h1000, 'h800, 'hFFF, 'h7FF)};
    tbl[4]  = '{fl:21'h0,     fs:21'h0,     e:5'd31, r:1'b0, exp:mk(1, 30, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{fl:21'h100000, fs:21'h0,    e:5'd20, r:1'b0, exp:mk(0, 2, 'h800, 'h400, 'h400, 'h200, 'h3FF, 'h1FF)};
    tbl[6]  = '{fl:21'h0,     fs:21'h0,     e:5'd12, r:1'b0, exp:mk(1, 11, 'h4, 'h2, 'h2, 'h1, 'h1, 'h0)};
    tbl[7]  = '{fl:21'h0,     fs:21'h0,     e:5'd13, r:1'b0, exp:mk(1, 12, 'h2, 'h1, 'h1, 0, 0, 0)};
    tbl[8]  = '{fl:21'h0,     fs:21'h0,     e:5'd14, r:1'b0, exp:mk(1, 13, 'h1, 0, 0, 0, 0, 0)};
    tbl[9]  = '{fl:21'h0,     fs:21'h0,     e:5'd15, r:1'b0, exp:mk(1, 14, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{fl:21'h0,     fs:21'h0,     e:5'd2,  r:1'b0, exp:mk(1, 1, 'h1000, 'h800, 'h800, 'h400, 'h7FF, 'h3FF)};
    tbl[11] = '{fl:21'h0,     fs:21'h0,     e:5'd2,  r:1'b1, exp:mk(1, 1, 'h1000, 'h800, 'h800, 'h400, 'h7FF, 'h3FF)};
    tbl[12] = '{fl:21'h0,     fs:21'h0,     e:5'd3,  r:1'b1, exp:mk(1, 2, 'h800, 'h400, 'h400, 'h200, 'h3FF, 'h1FF)};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    check_int("reset_out_valid", int'(bus.out_valid_o), 0);
    check_int("reset_in_ready", int'(bus.in_ready_o), 1);
    check_res("reset_data", read_dut(), '0);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      run_one($sformatf("vec%0d", i), tbl[i].fl, tbl[i].fs, tbl[i].e, tbl[i].r,
              tbl[i].exp, 1'b1);
    end

    // Backpressure stream: 8 inputs, out_ready low for cycles 3..6
    begin
      int sent, got, cyc;
      logic saw_block, acc;
      sent = 0; got = 0; cyc = 0; saw_block = 1'b0;
      for (int k = 0; k < 8; k++) stream_exp[k] = model('0, '0, 5'(2 + k), 1'b0);
      tick();
      while (got < 8 && cyc < 80) begin
        bus.out_ready_i = !(cyc >= 3 && cyc <= 6);
        bus.in_valid_i  = (sent < 8);
        drive('0, '0, 5'(2 + sent), 1'b0);
        #1;
        if (sent < 8 && !bus.in_ready_o) saw_block = 1'b1;
        acc = bus.in_valid_i & bus.in_ready_o;
        if (bus.out_valid_o && bus.out_ready_i) begin
          check_res($sformatf("stream%0d", got), read_dut(), stream_exp[got]);
          got++;
        end
        if (acc) sent++;
        tick();
        cyc++;
      end
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      check_int("stream_count", got, 8);
      check_int("stream_sent", sent, 8);
      check_int("stream_in_ready_dropped", int'(saw_block), 1);
      tick(); tick(); tick();
      check_int("stream_no_dup", int'(bus.out_valid_o), 0);
    end

    // Flush with entries in flight; the input offered with flush is dropped
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    drive('0, '0, 5'd6, 1'b0);
    tick();
    drive('0, '0, 5'd7, 1'b0);
    tick();
    bus.flush_i = 1'b1;
    drive('0, '0, 5'd8, 1'b0);
    tick();
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    check_int("flush_out_valid", int'(bus.out_valid_o), 0);
    check_int("flush_in_ready", int'(bus.in_ready_o), 1);
    bus.out_ready_i = 1'b1;
    tick(); tick(); tick();
    check_int("flush_dropped", int'(bus.out_valid_o), 0);
    run_one("post_flush", 21'h0, 21'h0, 5'd9, 1'b0, model('0, '0, 5'd9, 1'b0), 1'b1);

    // Mid-run reset clears valids and data
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    drive('0, '0, 5'd20, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    #1;
    check_int("midrst_out_valid", int'(bus.out_valid_o), 0);
    check_int("midrst_in_ready", int'(bus.in_ready_o), 1);
    check_res("midrst_data", read_dut(), '0);
    tick(); tick();
    check_int("midrst_no_output", int'(bus.out_valid_o), 0);

    // Exponent sweep with random fractions
    for (int e = 0; e < 32; e++) begin
      for (int k = 0; k < 3; k++) begin
        logic [20:0] fl, fs;
        logic r;
        fl = 21'($urandom);
        fs = 21'($urandom);
        r  = 1'($urandom_range(0, 1));
        run_one($sformatf("sweep_e%0d_%0d", e, k), fl, fs, 5'(e), r,
                model(fl, fs, 5'(e), r), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
